// File: rtl/d_mem_pkg.sv
// d_mem_pkg: shared FSM states, MMIO addresses and wait-counter width for the data-memory responder
package d_mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [31:0] MMIO_OUT_ADDR = 32'hFFFF_0000;
  localparam logic [31:0] MMIO_CNT_ADDR = 32'hFFFF_0004;
  localparam int CNT_W = 4;
endpackage

// File: rtl/d_mem_ram.sv
// d_mem_ram: DEPTH x 32 word array, synchronous write, synchronous read held until the next read
// Ports: clock, reset (async active-low, clears only the read register), we/wdata write port,
//        re/rdata read port, idx word index shared by both ports.
module d_mem_ram #(
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clock)
    if (we) mem[idx] <= wdata;
  always_ff @(posedge clock or negedge reset)
    if (!reset) rdata <= '0;
    else if (re) rdata <= mem[idx];
endmodule

// File: rtl/d_mem_responder.sv
// d_mem_responder: multi-cycle data-memory responder with LATENCY wait states and a one-cycle Ready pulse
// Ports: clock, reset (async active-low), MemRead/MemWrite/Address/WriteData request held until Ready,
//        ReadData/Ready/Error response, mmio_out MMIO output register (only with D_MEM_MMIO_EN).
// D_MEM_MMIO_EN adds the MMIO output register at MMIO_OUT_ADDR and a free-running cycle counter at MMIO_CNT_ADDR.
module d_mem_responder
  import d_mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        Error
`ifdef D_MEM_MMIO_EN
  ,
  output logic [31:0] mmio_out
`endif
);
  localparam int AW = $clog2(DEPTH);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [31:0] addr_q, wdata_q, data_q, a, wd, ram_rdata, mmio_rd;
  logic req_rd, req_wr, r, w, req, commit, in_arr, hit_out, hit_cnt, err, err_q, src_ram, ram_we, ram_re;
  assign req = MemRead | MemWrite;
  // With LATENCY=0 the access commits at the accepting edge, so decode must see the live request.
  assign a = state == IDLE ? Address : addr_q;
  assign wd = state == IDLE ? WriteData : wdata_q;
  assign r = state == IDLE ? MemRead : req_rd;
  assign w = state == IDLE ? MemWrite : req_wr;
  assign commit = (state == IDLE && req && LATENCY == 0) || (state == WAIT && cnt == CNT_W'(1));
  assign in_arr = a[31:AW+2] == '0;
`ifdef D_MEM_MMIO_EN
  logic [31:0] mmio_q, cyc;
  assign hit_out = a == MMIO_OUT_ADDR;
  assign hit_cnt = a == MMIO_CNT_ADDR;
  assign mmio_rd = hit_out ? mmio_q : cyc;
  assign mmio_out = mmio_q;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      mmio_q <= '0;
      cyc <= '0;
    end else begin
      cyc <= cyc + 32'd1;
      if (commit && w && !err && hit_out) mmio_q <= wd;
    end
`else
  assign hit_out = 1'b0;
  assign hit_cnt = 1'b0;
  assign mmio_rd = '0;
`endif
  assign err = (|a[1:0]) | (r & w) | ~(in_arr | hit_out | hit_cnt);
  assign ram_we = commit & w & ~err & in_arr;
  assign ram_re = commit & r & ~err & in_arr;
  d_mem_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clock(clock),
    .reset(reset),
    .we(ram_we),
    .re(ram_re),
    .idx(a[AW+1:2]),
    .wdata(wd),
    .rdata(ram_rdata)
  );
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (req ? (LATENCY == 0 ? RESP : WAIT) : IDLE) :
               state == WAIT ? (cnt == CNT_W'(1) ? RESP : WAIT) : IDLE;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      req_rd <= 1'b0;
      req_wr <= 1'b0;
      err_q <= 1'b0;
      data_q <= '0;
      src_ram <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req) begin
        cnt <= CNT_W'(LATENCY);
        addr_q <= Address;
        wdata_q <= WriteData;
        req_rd <= MemRead;
        req_wr <= MemWrite;
      end else if (state == WAIT) cnt <= cnt - CNT_W'(1);
      // ReadData comes from the RAM read register for array reads, else from data_q;
      // writes touch neither so the previous load value is held.
      if (commit) begin
        err_q <= err;
        if (err) begin
          data_q <= '0;
          src_ram <= 1'b0;
        end else if (r) begin
          data_q <= mmio_rd;
          src_ram <= in_arr;
        end
      end
    end
  assign ReadData = src_ram ? ram_rdata : data_q;
  assign Ready = state == RESP;
  assign Error = err_q;
endmodule

// File: tb/tb_d_mem_responder.sv
// tb_d_mem_responder: scoreboard bench for d_mem_responder with LATENCY=2 and LATENCY=0 instances
module tb_d_mem_responder;
  typedef struct {
    logic        e;
    logic [31:0] d;
    int          at;
    bit          chk;
  } exp_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst2 = 1'b1, rst0 = 1'b1;
  logic rd2 = 0, wr2 = 0, rd0 = 0, wr0 = 0;
  logic [31:0] a2 = 0, wd2 = 0, a0 = 0, wd0 = 0;
  logic [31:0] rdat2, rdat0, mo2, mo0;
  logic rdy2, err2, rdy0, err0;
  d_mem_responder #(.DEPTH(256), .LATENCY(2)) u2 (
    .clock(clk), .reset(rst2), .MemRead(rd2), .MemWrite(wr2), .Address(a2), .WriteData(wd2),
    .ReadData(rdat2), .Ready(rdy2), .Error(err2)
`ifdef D_MEM_MMIO_EN
    , .mmio_out(mo2)
`endif
  );
  d_mem_responder #(.DEPTH(256), .LATENCY(0)) u0 (
    .clock(clk), .reset(rst0), .MemRead(rd0), .MemWrite(wr0), .Address(a0), .WriteData(wd0),
    .ReadData(rdat0), .Ready(rdy0), .Error(err0)
`ifdef D_MEM_MMIO_EN
    , .mmio_out(mo0)
`endif
  );
`ifndef D_MEM_MMIO_EN
  assign mo2 = '0;
  assign mo0 = '0;
`endif
  exp_t q2[$], q0[$];
  logic [31:0] caps[$];
  exp_t m2, m0;
  int n_chk = 0, n_fail = 0, ncyc = 0, t0 = 0;
  logic prev2 = 0, prev0 = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    ncyc++;
    if (rdy2 === 1'b1) begin
      chk("u2 single-cycle Ready", {31'd0, prev2}, 32'd0);
      if (q2.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL u2 unexpected Ready at cycle %0d", ncyc);
      end else begin
        m2 = q2.pop_front();
        chk("u2 Error", {31'd0, err2}, {31'd0, m2.e});
        chk("u2 Ready timing", ncyc, m2.at);
        if (m2.chk) chk("u2 ReadData", rdat2, m2.d);
        else caps.push_back(rdat2);
      end
    end
    prev2 = rdy2;
    if (rdy0 === 1'b1) begin
      chk("u0 single-cycle Ready", {31'd0, prev0}, 32'd0);
      if (q0.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL u0 unexpected Ready at cycle %0d", ncyc);
      end else begin
        m0 = q0.pop_front();
        chk("u0 Error", {31'd0, err0}, {31'd0, m0.e});
        chk("u0 Ready timing", ncyc, m0.at);
        chk("u0 ReadData", rdat0, m0.d);
      end
    end
    prev0 = rdy0;
  end
  task automatic wait_rdy(input bit u);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1;
      if (u ? rdy2 : rdy0) return;
    end
    n_chk++; n_fail++;
    $display("FAIL %s Ready timeout", u ? "u2" : "u0");
  endtask
  task automatic req(input bit u, input bit r, input bit w, input logic [31:0] a, input logic [31:0] wd,
                     input logic e, input logic [31:0] d, input bit c = 1);
    exp_t x;
    @(negedge clk);
    #1;
    t0 = ncyc;
    x.e = e; x.d = d; x.chk = c;
    x.at = ncyc + (u ? 3 : 1);
    if (u) begin
      q2.push_back(x);
      rd2 = r; wr2 = w; a2 = a; wd2 = wd;
    end else begin
      q0.push_back(x);
      rd0 = r; wr0 = w; a0 = a; wd0 = wd;
    end
    wait_rdy(u);
    if (u) begin rd2 = 0; wr2 = 0; end
    else begin rd0 = 0; wr0 = 0; end
  endtask
  initial begin
    #1;
    rst2 = 0; rst0 = 0;
    #1;
    chk("reset u2 Ready", {31'd0, rdy2}, 32'd0);
    chk("reset u2 Error", {31'd0, err2}, 32'd0);
    chk("reset u2 ReadData", rdat2, 32'd0);
    chk("reset u0 Ready", {31'd0, rdy0}, 32'd0);
    chk("reset u0 ReadData", rdat0, 32'd0);
    chk("reset u2 mmio_out", mo2, 32'd0);
    @(negedge clk);
    #1;
    rst2 = 1; rst0 = 1;
    req(1, 0, 1, 32'h10, 32'hDEAD_BEEF, 0, 32'h0);
    req(1, 1, 0, 32'h10, 32'h0, 0, 32'hDEAD_BEEF);
    req(1, 1, 0, 32'h12, 32'h0, 1, 32'h0);
    req(1, 1, 0, 32'h1000, 32'h0, 1, 32'h0);
    req(1, 1, 0, 32'h10, 32'h0, 0, 32'hDEAD_BEEF);
    req(1, 0, 1, 32'h20, 32'h1111_2222, 0, 32'hDEAD_BEEF);
    req(1, 1, 1, 32'h20, 32'h99, 1, 32'h0);
    req(1, 1, 0, 32'h20, 32'h0, 0, 32'h1111_2222);
    req(1, 0, 1, 32'h40, 32'h1234, 0, 32'h1111_2222);
    @(negedge clk);
    #1;
    wr2 = 1; a2 = 32'h40; wd2 = 32'h5678;
    @(negedge clk);
    #1;
    rst2 = 0;
    #1;
    chk("abort Ready", {31'd0, rdy2}, 32'd0);
    chk("abort Error", {31'd0, err2}, 32'd0);
    chk("abort ReadData", rdat2, 32'd0);
    @(negedge clk);
    #1;
    wr2 = 0;
    rst2 = 1;
    req(1, 1, 0, 32'h40, 32'h0, 0, 32'h1234);
`ifdef D_MEM_MMIO_EN
    req(1, 0, 1, 32'hFFFF_0000, 32'hA5, 0, 32'h1234);
    chk("mmio_out", mo2, 32'hA5);
    req(1, 1, 0, 32'hFFFF_0000, 32'h0, 0, 32'hA5);
    req(1, 0, 1, 32'hFFFF_0004, 32'h7, 0, 32'hA5);
    req(1, 1, 0, 32'hFFFF_0004, 32'h0, 0, 32'h0, 0);
    while (ncyc < t0 + 9) @(negedge clk);
    req(1, 1, 0, 32'hFFFF_0004, 32'h0, 0, 32'h0, 0);
    if (caps.size() == 2) chk("counter delta", caps[1] - caps[0], 32'd10);
    else begin
      n_chk++; n_fail++;
      $display("FAIL counter captures: got %0d expected 2", caps.size());
    end
`else
    req(1, 1, 0, 32'hFFFF_0004, 32'h0, 1, 32'h0);
    req(1, 0, 1, 32'hFFFF_0000, 32'h5, 1, 32'h0);
`endif
    req(0, 0, 1, 32'h0, 32'h5, 0, 32'h0);
    req(0, 0, 1, 32'h4, 32'hA, 0, 32'h0);
    req(0, 0, 1, 32'h8, 32'hB, 0, 32'h0);
    req(0, 1, 0, 32'h0, 32'h0, 0, 32'h5);
    req(0, 1, 0, 32'h4, 32'h0, 0, 32'hA);
    req(0, 1, 0, 32'h8, 32'h0, 0, 32'hB);
    repeat (5) @(negedge clk);
    #1;
    chk("u2 responses outstanding", q2.size(), 32'd0);
    chk("u0 responses outstanding", q0.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
